nibble_pack_ctrl: RTL

Sequencer that slices 4-bit fields out of a byte-wide input stream and packs pairs of them into output bytes by concatenation. The first nibble accepted goes to the MSBs; the second goes to the LSBs.
Sits between a byte producer and a byte consumer. Uses a valid/ready handshake on both sides.
Also taps the 2-bit field [3:2] of the last accepted byte, for monitoring.

---
 rtl/nibble_pack_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/nibble_pack_ctrl.sv
// nibble_pack_ctrl: takes one 4-bit field per accepted input byte and packs
// two of them into an output byte, first nibble in the MSBs. A flush closes a
// half-filled byte with PAD_NIBBLE in the low nibble.
// Optional build macro NIBBLE_PARITY_EN adds out_parity (= ^out_data, registered).
module nibble_pack_ctrl #(
    parameter logic [3:0] PAD_NIBBLE = 4'h0,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sel,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy,
`ifdef NIBBLE_PARITY_EN
    output logic             out_parity,
`endif
    output logic [1:0]       field_c
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             busy_q, busy_d;
    logic [1:0]       field_c_q, field_c_d;
`ifdef NIBBLE_PARITY_EN
    logic             out_parity_q, out_parity_d;
`endif

    logic       accept;
    logic       handoff;
    logic [3:0] nib;

    // A full slot can still take a nibble in the same cycle it is drained.
    assign in_ready = (state_q != S_FULL) || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready;
    assign nib      = in_sel ? in_data[7:4] : in_data[3:0];

    // Next-state and next-output computation for the packing sequencer.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        field_c_d   = field_c_q;

        if (accept) begin
            field_c_d = in_data[3:2];
        end
        if (handoff) begin
            out_count_d = out_count_q + CNT_W'(1);
        end

        case (state_q)
            S_EMPTY: begin
                // flush has nothing to close here
                if (accept) begin
                    hold_d  = nib;
                    state_d = S_HALF;
                end
            end
            S_HALF: begin
                // a real nibble takes priority over a same-cycle flush
                if (accept) begin
                    out_data_d  = {hold_q, nib};
                    out_valid_d = 1'b1;
                    state_d     = S_FULL;
                end else if (flush) begin
                    out_data_d  = {hold_q, PAD_NIBBLE};
                    out_valid_d = 1'b1;
                    state_d     = S_FULL;
                end
            end
            S_FULL: begin
                // out_data is held until the consumer takes it
                if (handoff) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        hold_d  = nib;
                        state_d = S_HALF;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_EMPTY;
            end
        endcase

        busy_d = (state_d != S_EMPTY);
    end

`ifdef NIBBLE_PARITY_EN
    // Parity follows out_data so both change on the same edge.
    always_comb begin
        out_parity_d = ^out_data_d;
    end
`endif

    // State and registered outputs; reset discards any partial nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            hold_q       <= 4'h0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_count_q  <= '0;
            busy_q       <= 1'b0;
            field_c_q    <= 2'b00;
`ifdef NIBBLE_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            busy_q       <= busy_d;
            field_c_q    <= field_c_d;
`ifdef NIBBLE_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign busy       = busy_q;
    assign field_c    = field_c_q;
`ifdef NIBBLE_PARITY_EN
    assign out_parity = out_parity_q;
`endif

endmodule
